rom_ctrl: RTL and testbench

ROM_CTRL -- requirements
Module: rom_ctrl

---
 rtl/rom_ctrl.sv | 130 +++++++++++++
 tb/tb_rom_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ctrl.sv
// Two-client round-robin memory controller that first loads a floor(addr/3) table into the
// attached RAM, then serves single-cycle read/write requests with registered read-valid.
module rom_ctrl #(
    parameter int unsigned MEM_SIZE = 6,
    parameter int unsigned DATA_W   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reinit,
    input  logic                c0_req,
    input  logic                c0_we,
    input  logic [MEM_SIZE-1:0] c0_addr,
    input  logic [DATA_W-1:0]   c0_wdata,
    output logic                c0_gnt,
    output logic                c0_rvalid,
    output logic [DATA_W-1:0]   c0_rdata,
    input  logic                c1_req,
    input  logic                c1_we,
    input  logic [MEM_SIZE-1:0] c1_addr,
    input  logic [DATA_W-1:0]   c1_wdata,
    output logic                c1_gnt,
    output logic                c1_rvalid,
    output logic [DATA_W-1:0]   c1_rdata,
    output logic                init_done,
    output logic                mem_write,
    output logic                mem_read,
    output logic [MEM_SIZE-1:0] mem_addr_w,
    output logic [MEM_SIZE-1:0] mem_addr_r,
    output logic [DATA_W-1:0]   mem_datain,
    input  logic [DATA_W-1:0]   mem_dataout
);

    typedef enum logic [0:0] {StInit, StServe} state_e;

    localparam logic [MEM_SIZE-1:0] CntMax = '1;

    state_e              state_q, state_d;
    logic [MEM_SIZE-1:0] cnt_q, cnt_d;
    logic                prio_q, prio_d;      // 0: client 0 wins a tie, 1: client 1 wins
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;

    logic [31:0]         cnt_div3;
    logic                gnt_we;
    logic [MEM_SIZE-1:0] gnt_addr;
    logic [DATA_W-1:0]   gnt_wdata;

    assign cnt_div3 = 32'(cnt_q) / 32'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        c0_gnt     = 1'b0;
        c1_gnt     = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        mem_addr_w = '0;
        mem_addr_r = '0;
        mem_datain = '0;
        gnt_we     = c1_gnt ? c1_we : c0_we;
        gnt_addr   = '0;
        gnt_wdata  = '0;

        unique case (state_q)
            StInit: begin
                mem_write  = 1'b1;
                mem_addr_w = cnt_q;
                mem_datain = DATA_W'(cnt_div3);
                cnt_d      = cnt_q + MEM_SIZE'(1);
                if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = StServe;
                end
            end
            StServe: begin
                if (reinit) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end else begin
                    c0_gnt    = c0_req && (!c1_req || !prio_q);
                    c1_gnt    = c1_req && !c0_gnt;
                    gnt_we    = c1_gnt ? c1_we : c0_we;
                    gnt_addr  = c1_gnt ? c1_addr : c0_addr;
                    gnt_wdata = c1_gnt ? c1_wdata : c0_wdata;
                    if (c0_gnt || c1_gnt) begin
                        prio_d = c0_gnt;
                        if (gnt_we) begin
                            mem_write  = 1'b1;
                            mem_addr_w = gnt_addr;
                            mem_datain = gnt_wdata;
                        end else begin
                            mem_read   = 1'b1;
                            mem_addr_r = gnt_addr;
                        end
                    end
                    rvalid0_d = c0_gnt && !c0_we;
                    rvalid1_d = c1_gnt && !c1_we;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign init_done = (state_q == StServe);
    assign c0_rvalid = rvalid0_q;
    assign c1_rvalid = rvalid1_q;
    // Read data is only meaningful alongside rvalid, so both clients share the RAM output.
    assign c0_rdata  = mem_dataout;
    assign c1_rdata  = mem_dataout;

endmodule

// File: tb/tb_rom_ctrl.sv
// Bench for rom_ctrl: behavioural RAM, an abstract reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_rom_ctrl;

    localparam int MS    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clk, rst, reinit;
    logic          c0_req, c0_we, c0_gnt, c0_rvalid;
    logic [MS-1:0] c0_addr;
    logic [DW-1:0] c0_wdata, c0_rdata;
    logic          c1_req, c1_we, c1_gnt, c1_rvalid;
    logic [MS-1:0] c1_addr;
    logic [DW-1:0] c1_wdata, c1_rdata;
    logic          init_done, mem_write, mem_read;
    logic [MS-1:0] mem_addr_w, mem_addr_r;
    logic [DW-1:0] mem_datain, mem_dataout;

    rom_ctrl #(.MEM_SIZE(MS), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .reinit(reinit),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .init_done(init_done), .mem_write(mem_write), .mem_read(mem_read),
        .mem_addr_w(mem_addr_w), .mem_addr_r(mem_addr_r),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached RAM: registered read, write visible to a same-cycle read of that address.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr_w] <= mem_datain;
        if (mem_read)
            mem_dataout <= (mem_write && mem_addr_w == mem_addr_r) ? mem_datain : mem[mem_addr_r];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the table holds, whether serving, whose turn, owed reads.
    bit serving;
    int load_idx;
    bit turn;
    int ref_mem [DEPTH];
    bit pv [2];
    int pd [2];
    bit nv [2];
    int nd [2];
    bit m_g0, m_g1;

    function automatic void arb(output bit g0, output bit g1);
        g0 = serving && !reinit && c0_req && (!c1_req || turn == 1'b0);
        g1 = serving && !reinit && c1_req && !g0;
    endfunction

    task automatic model_reset();
        serving  = 1'b0;
        load_idx = 0;
        turn     = 1'b0;
        pv[0]    = 1'b0;
        pv[1]    = 1'b0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            nv[0] = 1'b0;
            nv[1] = 1'b0;
            if (!serving) begin
                ref_mem[load_idx] = load_idx / 3;
                load_idx++;
                if (load_idx == DEPTH) begin
                    serving  = 1'b1;
                    load_idx = 0;
                end
            end else if (reinit) begin
                serving  = 1'b0;
                load_idx = 0;
            end else begin
                arb(m_g0, m_g1);
                if (m_g0) begin
                    if (c0_we) ref_mem[c0_addr] = int'(c0_wdata);
                    else begin nv[0] = 1'b1; nd[0] = ref_mem[c0_addr]; end
                    turn = 1'b1;
                end else if (m_g1) begin
                    if (c1_we) ref_mem[c1_addr] = int'(c1_wdata);
                    else begin nv[1] = 1'b1; nd[1] = ref_mem[c1_addr]; end
                    turn = 1'b0;
                end
            end
            pv = nv;
            pd = nd;
        end
    end

    bit e_g0, e_g1, e_w, e_r;
    int e_aw, e_ar, e_di;

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            check("rst_c0_gnt", c0_gnt, 0);
            check("rst_c1_gnt", c1_gnt, 0);
            check("rst_c0_rvalid", c0_rvalid, 0);
            check("rst_c1_rvalid", c1_rvalid, 0);
            check("rst_init_done", init_done, 0);
            check("rst_mem_read", mem_read, 0);
        end else begin
            arb(e_g0, e_g1);
            e_w = 0; e_r = 0; e_aw = 0; e_ar = 0; e_di = 0;
            if (!serving) begin
                e_w = 1; e_aw = load_idx; e_di = load_idx / 3;
            end else if (e_g0 || e_g1) begin
                if (e_g0 ? c0_we : c1_we) begin
                    e_w  = 1;
                    e_aw = e_g0 ? int'(c0_addr) : int'(c1_addr);
                    e_di = e_g0 ? int'(c0_wdata) : int'(c1_wdata);
                end else begin
                    e_r  = 1;
                    e_ar = e_g0 ? int'(c0_addr) : int'(c1_addr);
                end
            end
            check("m_init_done", init_done, serving);
            check("m_c0_gnt", c0_gnt, e_g0);
            check("m_c1_gnt", c1_gnt, e_g1);
            check("m_mem_write", mem_write, e_w);
            check("m_mem_read", mem_read, e_r);
            check("m_mem_addr_w", mem_addr_w, e_aw);
            check("m_mem_addr_r", mem_addr_r, e_ar);
            check("m_mem_datain", mem_datain, e_di);
            check("m_c0_rvalid", c0_rvalid, pv[0]);
            check("m_c1_rvalid", c1_rvalid, pv[1]);
            if (pv[0]) check("m_c0_rdata", c0_rdata, pd[0]);
            if (pv[1]) check("m_c1_rdata", c1_rdata, pd[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!init_done && n < 200) begin
            cyc();
            n++;
        end
        check(name, n, 64);
    endtask

    bit prev_g0;

    initial begin
        rst = 1'b1; reinit = 1'b0;
        c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table load
        #1 check("first_init_addr", mem_addr_w, 0);
        wait_init("init_cycles");
        check("tbl_mem0", mem[0], 0);
        check("tbl_mem3", mem[3], 1);
        check("tbl_mem63", mem[63], 21);
        check("ref_mem63", ref_mem[63], 21);

        // Single read by c0
        c0_req = 1; c0_we = 0; c0_addr = 6'd10;
        #1 check("rd10_gnt", c0_gnt, 1);
        cyc();
        c0_req = 0;
        #1 check("rd10_rvalid", c0_rvalid, 1);
        check("rd10_rdata", c0_rdata, 3);
        check("rd10_c1_rvalid", c1_rvalid, 0);

        // Both clients read continuously
        c0_req = 1; c0_addr = 6'd7; c1_req = 1; c1_we = 0; c1_addr = 6'd8;
        for (int i = 0; i < 8; i++) begin
            #1 check("rr_onehot", 32'(c0_gnt) + 32'(c1_gnt), 1);
            if (i > 0) check("rr_alternate", c0_gnt, !prev_g0);
            prev_g0 = c0_gnt;
            cyc();
            if (prev_g0) begin
                check("rr_c0_rvalid", c0_rvalid, 1);
                check("rr_c0_rdata", c0_rdata, 2);
            end else begin
                check("rr_c1_rvalid", c1_rvalid, 1);
                check("rr_c1_rdata", c1_rdata, 2);
            end
        end
        c0_req = 0; c1_req = 0;
        cyc();

        // c1 write then c0 read of same address
        c1_req = 1; c1_we = 1; c1_addr = 6'd5; c1_wdata = 10'h3FF;
        #1 check("wr5_gnt", c1_gnt, 1);
        cyc();
        c1_req = 0; c1_we = 0;
        c0_req = 1; c0_we = 0; c0_addr = 6'd5;
        #1 check("wr5_c1_rvalid", c1_rvalid, 0);
        check("rd5_gnt", c0_gnt, 1);
        cyc();
        c0_req = 0;
        #1 check("rd5_rdata", c0_rdata, 10'h3FF);
        cyc();

        // reinit one cycle after a granted c1 read
        c1_req = 1; c1_addr = 6'd9;
        #1 check("ri_c1_gnt", c1_gnt, 1);
        cyc();
        c1_req = 0; reinit = 1; c0_req = 1; c0_we = 0; c0_addr = 6'd10;
        #1 check("ri_c0_gnt", c0_gnt, 0);
        check("ri_c1_rvalid", c1_rvalid, 1);
        check("ri_c1_rdata", c1_rdata, 3);
        cyc();
        reinit = 0;
        #1 check("ri_init_done", init_done, 0);
        check("ri_mem_addr_w", mem_addr_w, 0);
        wait_init("reinit_cycles");
        check("ri_c0_first_gnt", c0_gnt, 1);
        cyc();
        c0_addr = 6'd5;
        #1 check("ri_c0_rdata", c0_rdata, 3);
        cyc();
        c0_req = 0;
        #1 check("ri_reloaded5", c0_rdata, 1);

        // Reset in the middle of the table load
        rst = 1;
        cyc();
        rst = 0;
        repeat (30) cyc();
        check("mid_cnt30", mem_addr_w, 30);
        c0_req = 1; c0_addr = 6'd1;
        rst = 1;
        #1 check("mid_init_done", init_done, 0);
        check("mid_c0_gnt", c0_gnt, 0);
        check("mid_mem_read", mem_read, 0);
        check("mid_addr_w", mem_addr_w, 0);
        cyc();
        cyc();
        rst = 0;
        #1 check("mid_restart_addr", mem_addr_w, 0);
        check("mid_restart_we", mem_write, 1);
        wait_init("mid_reload_cycles");
        c0_req = 0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
